// File: rtl/stream_arb2_rr.sv
// Two-input round-robin stream arbiter with a registered output stage.
// out_src is the per-beat select that drives the downstream 2:1 data mux.
module stream_arb2_rr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    logic last_grant_q;
    logic load_en;
    logic grant;
    logic take;

    // The register may take a beat while it is being drained, giving 1 beat/cycle.
    assign load_en = !out_valid || out_ready;

    always_comb begin
        grant = 1'b0;
        if (in0_valid && in1_valid) begin
            grant = !last_grant_q;
        end else if (in1_valid) begin
            grant = 1'b1;
        end
    end

    assign in0_ready = load_en && in0_valid && !grant;
    assign in1_ready = load_en && in1_valid && grant;
    assign take      = in0_ready || in1_ready;

    // Priority rotates only on an accepted beat; idle and stalled cycles keep it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_src      <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (take) begin
            out_valid    <= 1'b1;
            out_data     <= grant ? in1_data : in0_data;
            out_src      <= grant;
            last_grant_q <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_arb2_rr.sv
// Bench for stream_arb2_rr: directed scenarios, then randomized traffic against
// a contention-preference model with per-source scoreboard queues.
module tb_stream_arb2_rr;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    int total = 0;
    int bad   = 0;

    stream_arb2_rr #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random-phase model state
    logic                   m_valid;
    logic [WIDTH-1:0]       m_data;
    logic                   m_src;
    logic                   m_favor;
    logic [WIDTH-1:0]       q0[$];
    logic [WIDTH-1:0]       q1[$];
    logic [WIDTH-1:0]       exp_d;
    logic                   v0, v1, can_load, e0, e1, h0, h1;
    int                     w0, w1;

    initial begin
        rst_n     = 1'b0;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_src", 32'(out_src), 32'd0);

        // Both valid continuously: alternating beats starting with in0
        in0_valid = 1'b1; in0_data = 8'h11;
        in1_valid = 1'b1; in1_data = 8'h22;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("t1_rdy0", 32'(in0_ready), 32'd1);
        check("t1_rdy1", 32'(in1_ready), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("t1_valid", 32'(out_valid), 32'd1);
            check("t1_data", 32'(out_data), (i % 2 == 1) ? 32'h22 : 32'h11);
            check("t1_src", 32'(out_src), 32'(i % 2));
        end

        // Only in1 valid, then contention goes to in0
        do_reset();
        in1_valid = 1'b1; in1_data = 8'hA5; out_ready = 1'b1;
        #1;
        check("t2_rdy1", 32'(in1_ready), 32'd1);
        check("t2_rdy0", 32'(in0_ready), 32'd0);
        @(posedge clk);
        #1;
        in0_valid = 1'b1; in0_data = 8'h11; in1_data = 8'h22;
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_data", 32'(out_data), 32'hA5);
        check("t2_src", 32'(out_src), 32'd1);
        check("t2_win0", 32'(in0_ready), 32'd1);
        check("t2_lose1", 32'(in1_ready), 32'd0);

        // Backpressure holds the beat and blocks both inputs
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_rdy0", 32'(in0_ready), 32'd0);
            check("t3_rdy1", 32'(in1_ready), 32'd0);
            check("t3_data", 32'(out_data), 32'h11);
            check("t3_src", 32'(out_src), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t3_rel_rdy1", 32'(in1_ready), 32'd1);
        check("t3_rel_rdy0", 32'(in0_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t3_data2", 32'(out_data), 32'h22);
        check("t3_src2", 32'(out_src), 32'd1);

        // Idle gap keeps priority
        in0_valid = 1'b0; in1_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t4_drain", 32'(out_valid), 32'd0);
        check("t4_src_hold", 32'(out_src), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in0_valid = 1'b1; in1_valid = 1'b1;
        #1;
        check("t4_rdy0", 32'(in0_ready), 32'd1);
        check("t4_rdy1", 32'(in1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t4_data", 32'(out_data), 32'h11);
        check("t4_src", 32'(out_src), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t5_rdy0", 32'(in0_ready), 32'd1);
        check("t5_rdy1", 32'(in1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("t5_src", 32'(out_src), 32'd0);
        check("t5_data", 32'(out_data), 32'h11);

        // Randomized traffic
        do_reset();
        m_valid = 1'b0; m_data = '0; m_src = 1'b0; m_favor = 1'b0;
        v0 = 1'b0; v1 = 1'b0; w0 = 0; w1 = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!v0 && $urandom_range(0, 99) < 60) begin
                v0 = 1'b1;
                in0_data = {1'b0, 7'($urandom)};
            end
            if (!v1 && $urandom_range(0, 99) < 60) begin
                v1 = 1'b1;
                in1_data = {1'b1, 7'($urandom)};
            end
            in0_valid = v0;
            in1_valid = v1;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            can_load = !m_valid || out_ready;
            e0 = can_load && v0 && (!v1 || m_favor == 1'b0);
            e1 = can_load && v1 && (!v0 || m_favor == 1'b1);
            check("r_rdy0", 32'(in0_ready), 32'(e0));
            check("r_rdy1", 32'(in1_ready), 32'(e1));
            check("r_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("r_data", 32'(out_data), 32'(m_data));
                check("r_src", 32'(out_src), 32'(m_src));
                check("r_src_tag", 32'(out_data[WIDTH-1]), 32'(out_src));
            end
            // Scoreboard: each drained beat must be the oldest pending beat of its source
            if (m_valid && out_ready) begin
                if (out_src == 1'b0 && q0.size() > 0) begin
                    exp_d = q0.pop_front();
                    check("sb_order0", 32'(out_data), 32'(exp_d));
                end else if (out_src == 1'b1 && q1.size() > 0) begin
                    exp_d = q1.pop_front();
                    check("sb_order1", 32'(out_data), 32'(exp_d));
                end else begin
                    check("sb_dup", 32'd1, 32'd0);
                end
            end
            h0 = e0;
            h1 = e1;
            if (h0) begin
                check("fair0", 32'(w0 <= 1), 32'd1);
                w0 = 0;
                q0.push_back(in0_data);
                m_data = in0_data; m_src = 1'b0; m_valid = 1'b1; m_favor = 1'b1;
                v0 = 1'b0;
                if (v1) w1++;
            end else if (h1) begin
                check("fair1", 32'(w1 <= 1), 32'd1);
                w1 = 0;
                q1.push_back(in1_data);
                m_data = in1_data; m_src = 1'b1; m_valid = 1'b1; m_favor = 1'b0;
                v1 = 1'b0;
                if (v0) w0++;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("sb_left", 32'(q0.size() + q1.size()), 32'(m_valid));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
